// File: rtl/ifetch_pkg.sv
// Shared types, defaults and small arithmetic helpers for the instruction fetch unit.
package ifetch_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    READY  = 3'd1,
    DRAIN  = 3'd2,
    HALTED = 3'd3,
    FAULT  = 3'd4
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;

  function automatic logic [31:0] pc_plus4(input logic [31:0] a);
    return a + 32'd4;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

endpackage

// File: rtl/ifetch_pbuf.sv
// One-entry prefetch buffer that also owns the memory request (address + outstanding flag),
// so imem_req/imem_addr come straight from its registers.
module ifetch_pbuf
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue,
  input  logic [31:0] issue_addr,
  input  logic        fill,
  input  logic [31:0] fill_data,
  input  logic        retire,
  input  logic        flush,
  output logic [31:0] buf_data,
  output logic [31:0] buf_addr,
  output logic        buf_valid,
  output logic        buf_outstanding
);

  logic [31:0] data_r;
  logic [31:0] addr_r;
  logic        valid_r;
  logic        out_r;

  // Request/buffer registers; reset leaves the first fetch already on the bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r  <= 32'h0000_0000;
      addr_r  <= RESET_ADDR;
      valid_r <= 1'b0;
      out_r   <= 1'b1;
    end else begin
      if (issue) begin
        addr_r <= issue_addr;
        out_r  <= 1'b1;
      end else if (fill || retire) begin
        out_r  <= 1'b0;
      end
      if (fill) begin
        data_r  <= fill_data;
        valid_r <= 1'b1;
      end else if (flush) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign buf_data        = data_r;
  assign buf_addr        = addr_r;
  assign buf_valid       = valid_r;
  assign buf_outstanding = out_r;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: demand fetch, single-word prefetch with zero-bubble sequential
// advance, redirect draining, halt and misaligned-PC fault handling.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_next,
  input  logic        advance,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic        fault,
  output logic [15:0] discard_cnt
);

  fetch_state_t state_r, state_s;
  logic [31:0]  pc_r, pc_s;
  logic [31:0]  instr_r, instr_s;
  logic         valid_r, valid_s;
  logic         fault_r, fault_s;
  logic [15:0]  discard_r, discard_s;

  logic         issue_s, fill_s, retire_s, flush_s;
  logic [31:0]  issue_addr_s;
  logic [31:0]  buf_data_s, buf_addr_s;
  logic         buf_valid_s, buf_out_s;
  logic         ack_s, seq_s, misaligned_s;

  ifetch_pbuf #(.RESET_ADDR(RESET_PC)) u_pbuf (
    .clk             (clk),
    .reset           (reset),
    .issue           (issue_s),
    .issue_addr      (issue_addr_s),
    .fill            (fill_s),
    .fill_data       (imem_rdata),
    .retire          (retire_s),
    .flush           (flush_s),
    .buf_data        (buf_data_s),
    .buf_addr        (buf_addr_s),
    .buf_valid       (buf_valid_s),
    .buf_outstanding (buf_out_s)
  );

  // Acks with nothing on the bus are stray and must not be consumed.
  assign ack_s        = imem_ack & buf_out_s;
  assign seq_s        = (pc_next == pc_plus4(pc_r));
  assign misaligned_s = (pc_next[1:0] != 2'b00);

  // Next-state and buffer control decode.
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    instr_s      = instr_r;
    valid_s      = valid_r;
    fault_s      = fault_r;
    discard_s    = discard_r;
    issue_s      = 1'b0;
    issue_addr_s = pc_plus4(pc_r);
    fill_s       = 1'b0;
    retire_s     = 1'b0;
    flush_s      = 1'b0;
    case (state_r)
      FETCH: begin
        if (ack_s) begin
          instr_s = imem_rdata;
          valid_s = 1'b1;
          state_s = READY;
          issue_s = 1'b1;
        end else begin
          state_s = FETCH;
        end
      end
      READY: begin
        if (halt) begin
          state_s  = HALTED;
          retire_s = 1'b1;
        end else if (!advance) begin
          if (ack_s) begin
            fill_s = 1'b1;
          end else if (!buf_valid_s && !buf_out_s) begin
            issue_s = 1'b1;
          end else begin
            state_s = READY;
          end
        end else if (misaligned_s) begin
          fault_s  = 1'b1;
          state_s  = FAULT;
          valid_s  = 1'b0;
          instr_s  = NOP_INSTR;
          retire_s = 1'b1;
          flush_s  = 1'b1;
        end else if (seq_s && (buf_valid_s || ack_s)) begin
          pc_s         = pc_next;
          instr_s      = buf_valid_s ? buf_data_s : imem_rdata;
          flush_s      = 1'b1;
          issue_s      = 1'b1;
          issue_addr_s = pc_plus4(pc_next);
        end else if (seq_s && buf_out_s) begin
          // The in-flight prefetch already targets pc_next; keep it as the demand fetch.
          pc_s    = pc_next;
          instr_s = NOP_INSTR;
          valid_s = 1'b0;
          state_s = FETCH;
        end else begin
          pc_s    = pc_next;
          instr_s = NOP_INSTR;
          valid_s = 1'b0;
          flush_s = 1'b1;
          if (buf_valid_s || buf_out_s) begin
            discard_s = sat_inc16(discard_r);
          end else begin
            discard_s = discard_r;
          end
          if (buf_out_s && !ack_s) begin
            state_s = DRAIN;
          end else begin
            state_s      = FETCH;
            issue_s      = 1'b1;
            issue_addr_s = pc_next;
          end
        end
      end
      DRAIN: begin
        if (ack_s) begin
          state_s      = FETCH;
          issue_s      = 1'b1;
          issue_addr_s = pc_r;
        end else begin
          state_s = DRAIN;
        end
      end
      HALTED, FAULT: begin
        state_s = state_r;
      end
      default: begin
        state_s      = FETCH;
        valid_s      = 1'b0;
        instr_s      = NOP_INSTR;
        flush_s      = 1'b1;
        issue_s      = 1'b1;
        issue_addr_s = pc_r;
      end
    endcase
  end

  // Architectural state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= FETCH;
      pc_r      <= RESET_PC;
      instr_r   <= NOP_INSTR;
      valid_r   <= 1'b0;
      fault_r   <= 1'b0;
      discard_r <= 16'h0000;
    end else begin
      state_r   <= state_s;
      pc_r      <= pc_s;
      instr_r   <= instr_s;
      valid_r   <= valid_s;
      fault_r   <= fault_s;
      discard_r <= discard_s;
    end
  end

  assign imem_req    = buf_out_s;
  assign imem_addr   = buf_addr_s;
  assign instruction = instr_r;
  assign instr_valid = valid_r;
  assign pc          = pc_r;
  assign fault       = fault_r;
  assign discard_cnt = discard_r;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level reference model.
module tb_ifetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_next = 32'd0;
  logic        advance = 1'b0;
  logic        halt = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] pc;
  logic        fault;
  logic [15:0] discard_cnt;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;
  bit stray_en = 1'b0;
  int lat_v = 1;
  int wcnt = 0;

  ifetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .pc_next(pc_next), .advance(advance), .halt(halt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instruction), .instr_valid(instr_valid), .pc(pc), .fault(fault),
    .discard_cnt(discard_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: current instruction, prefetched words and the bus request in flight.
  logic [31:0] m_pc, m_instr, m_req_addr;
  logic [31:0] m_buf[$];
  logic [15:0] m_disc;
  bit m_have, m_halted, m_faulted, m_req_on, m_draining, m_fault;

  always @(posedge clk) begin : model
    bit got;
    got = imem_ack && m_req_on;
    if (reset) begin
      m_pc = RST_PC; m_instr = NOP; m_have = 0; m_buf.delete();
      m_req_on = 1; m_req_addr = RST_PC; m_draining = 0;
      m_halted = 0; m_faulted = 0; m_fault = 0; m_disc = 16'd0;
    end else if (m_halted || m_faulted) begin
      m_req_on = 0;
    end else if (!m_have) begin
      if (got && m_draining) begin
        m_draining = 0; m_req_addr = m_pc;
      end else if (got) begin
        m_instr = imem_rdata; m_have = 1; m_req_addr = m_pc + 32'd4;
      end
    end else if (halt) begin
      m_halted = 1; m_req_on = 0;
    end else if (!advance) begin
      if (got) begin
        m_buf.push_back(imem_rdata); m_req_on = 0;
      end else if (m_buf.size() == 0 && !m_req_on) begin
        m_req_on = 1; m_req_addr = m_pc + 32'd4;
      end
    end else if (pc_next[1:0] != 2'b00) begin
      m_faulted = 1; m_fault = 1; m_have = 0; m_instr = NOP; m_req_on = 0; m_buf.delete();
    end else if (pc_next == m_pc + 32'd4 && (m_buf.size() > 0 || got)) begin
      if (m_buf.size() > 0) m_instr = m_buf.pop_front();
      else m_instr = imem_rdata;
      m_pc = pc_next; m_req_on = 1; m_req_addr = pc_next + 32'd4;
    end else if (pc_next == m_pc + 32'd4 && m_req_on) begin
      m_pc = pc_next; m_have = 0; m_instr = NOP;
    end else begin
      if (m_buf.size() > 0 || m_req_on) m_disc = (m_disc == 16'hFFFF) ? m_disc : m_disc + 16'd1;
      m_buf.delete(); m_pc = pc_next; m_have = 0; m_instr = NOP;
      if (m_req_on && !got) m_draining = 1;
      else begin m_req_on = 1; m_req_addr = pc_next; end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_req", imem_req, m_req_on);
      if (m_req_on) chk("imem_addr", imem_addr, m_req_addr);
      chk("instr_valid", instr_valid, m_have);
      chk("instruction", instruction, m_instr);
      chk("pc", pc, m_pc);
      chk("fault", fault, m_fault);
      chk("discard_cnt", discard_cnt, m_disc);
    end
  end

  // One cycle: advance past the edge, then let the memory respond for this cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    if (reset) begin
      wcnt = 0; imem_ack = 1'b0;
    end else if (imem_req) begin
      if (wcnt >= lat_v) begin
        imem_ack = 1'b1; imem_rdata = mem_word(imem_addr); wcnt = 0;
      end else begin
        imem_ack = 1'b0; wcnt++;
      end
    end else begin
      wcnt = 0;
      imem_ack = stray_en && ($urandom_range(0, 3) == 0);
      imem_rdata = $urandom;
    end
  endtask

  task automatic do_reset(input int lat);
    lat_v = lat; reset = 1'b1; advance = 1'b0; halt = 1'b0; pc_next = 32'd0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst pc", pc, RST_PC);
    chk("rst instr_valid", instr_valid, 32'd0);
    chk("rst instruction", instruction, NOP);
    chk("rst fault", fault, 32'd0);
    chk("rst discard_cnt", discard_cnt, 32'd0);
    chk("rst imem_addr", imem_addr, RST_PC);
    reset = 1'b0;
  endtask

  logic [31:0] seq_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};

  initial begin
    // Startup latency with a one-cycle registered memory.
    do_reset(1);
    tick();
    chk("c1 imem_req", imem_req, 32'd1);
    chk("c1 imem_addr", imem_addr, 32'h0);
    tick();
    chk("c2 instr_valid", instr_valid, 32'd0);
    tick();
    chk("c3 instr_valid", instr_valid, 32'd1);
    chk("c3 instruction", instruction, mem_word(32'h0));

    // Zero-bubble sequential run with same-cycle acks.
    do_reset(0);
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i < 4) chk("seq pc", pc, seq_pc[i]);
      chk("seq instr_valid", instr_valid, 32'd1);
      advance = 1'b1; pc_next = m_pc + 32'd4;
    end
    advance = 1'b0;

    // Branch while the prefetch of 0x8 is in flight.
    do_reset(1);
    tick(); tick(); tick();
    tick();
    advance = 1'b1; pc_next = 32'h4;
    tick();
    chk("br prefetch addr", imem_addr, 32'h8);
    advance = 1'b1; pc_next = 32'h40;
    tick();
    advance = 1'b0;
    chk("drain imem_addr", imem_addr, 32'h8);
    chk("drain instr_valid", instr_valid, 32'd0);
    chk("drain discard_cnt", discard_cnt, 32'd1);
    tick();
    chk("redirect imem_req", imem_req, 32'd1);
    chk("redirect imem_addr", imem_addr, 32'h40);
    tick(); tick();
    chk("redirect instruction", instruction, mem_word(32'h40));

    // Misaligned target faults and stops fetching.
    do_reset(0);
    tick(); tick();
    advance = 1'b1; pc_next = 32'h42;
    tick();
    advance = 1'b0;
    chk("fault flag", fault, 32'd1);
    chk("fault instr_valid", instr_valid, 32'd0);
    chk("fault pc", pc, 32'h0);
    chk("fault imem_req", imem_req, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      advance = 1'b1; pc_next = 32'h8;
    end
    advance = 1'b0;
    chk("fault imem_req later", imem_req, 32'd0);

    // Halt wins over advance.
    do_reset(0);
    tick(); tick();
    halt = 1'b1; advance = 1'b1; pc_next = 32'h4;
    tick();
    halt = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    advance = 1'b0;
    chk("halt pc", pc, 32'h0);
    chk("halt instruction", instruction, mem_word(32'h0));
    chk("halt instr_valid", instr_valid, 32'd1);
    chk("halt imem_req", imem_req, 32'd0);

    // Reset during a drain, with a stale ack landing while reset is held.
    do_reset(2);
    tick(); tick(); tick(); tick();
    advance = 1'b1; pc_next = 32'h80;
    tick();
    advance = 1'b0;
    chk("pre-rst discard_cnt", discard_cnt, 32'd1);
    reset = 1'b1;
    tick();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    reset = 1'b0;
    tick();
    chk("post-rst imem_addr", imem_addr, RST_PC);
    chk("post-rst discard_cnt", discard_cnt, 32'd0);
    tick(); tick(); tick();
    chk("post-rst instruction", instruction, mem_word(RST_PC));

    // Randomized traffic with stray acks and varying memory latency.
    stray_en = 1'b1;
    for (int r = 0; r < 40; r++) begin
      do_reset($urandom_range(0, 3));
      for (int k = 0; k < 80; k++) begin
        int q;
        tick();
        halt = ($urandom_range(0, 99) < 1);
        advance = ($urandom_range(0, 3) != 0);
        q = $urandom_range(0, 99);
        if (q < 72) pc_next = m_pc + 32'd4;
        else if (q < 92) pc_next = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
        else if (q < 97) pc_next = 32'hFFFF_FFF8;
        else pc_next = m_pc + 32'd2;
      end
    end
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
